// File: rtl/sevens_pkg.sv
// Shared definitions for the seven-segment display path.
// Used by the encoders and by seven_segment_scanner / pwm_dimmer.
//   seg_t      : active-low cathode pattern {dp,g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
//   SEG_DP     : bit position of the decimal point
package sevens_pkg;
    typedef logic [7:0] seg_t;
    localparam seg_t SEG_BLANK = 8'hFF;
    localparam int SEG_DP = 7;
endpackage

// File: rtl/pwm_dimmer.sv
// 4-bit PWM counter used for 16-level brightness.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   restart     : forces the counter to 0 in this cycle (first active slot cycle)
//   brightness  : 0 = 1/16 duty .. 15 = always on, sampled live
//   lit         : high when the current PWM value is <= brightness
module pwm_dimmer
    import sevens_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] brightness,
    output logic       lit
);

    logic [3:0] pwm_q;
    logic [3:0] pwm_cur;

    // The restart cycle itself must see a count of 0, so the value used this
    // cycle is muxed rather than waiting for the register to clear.
    assign pwm_cur = restart ? 4'd0 : pwm_q;
    assign lit     = (pwm_cur <= brightness);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_cur + 4'd1;  // natural wrap at 16
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit display.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   segments_in   : active-low cathode pattern per digit, index 0 = rightmost
//   blink_mask    : 1 = digit blinks
//   brightness    : 0 = 1/16 duty .. 15 = full on (live)
//   an            : active-low anode enables, registered
//   ca            : active-low cathodes {dp,g..a}, registered
//   frame_strobe  : one-cycle pulse on the last cycle of each frame
// Each digit slot starts with BLANK_CYCLES dark cycles (anti-ghosting), then
// shows the digit PWM-dimmed. Inputs are captured once per frame, on the
// frame_strobe cycle, so a frame never mixes old and new data.
module seven_segment_scanner
    import sevens_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 100,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                   clk,
    input  logic                   reset,
    input  seg_t [DIGITS-1:0]      segments_in,
    input  logic [DIGITS-1:0]      blink_mask,
    input  logic [3:0]             brightness,
    output logic [DIGITS-1:0]      an,
    output seg_t                   ca,
    output logic                   frame_strobe
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]  slot_cnt;
    logic [DIG_W-1:0]   digit_idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;
    seg_t [DIGITS-1:0]  seg_snap;
    logic [DIGITS-1:0]  blink_snap;

    logic slot_last;
    logic frame_last;
    logic active;
    logic restart;
    logic pwm_lit;
    logic digit_on;

    assign slot_last  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign frame_last = slot_last && (digit_idx == DIG_W'(DIGITS - 1));
    assign active     = (slot_cnt >= SLOT_W'(BLANK_CYCLES));
    assign restart    = (slot_cnt == SLOT_W'(BLANK_CYCLES));

    // Strobe is decoded from the counters so it coincides with the capture edge.
    assign frame_strobe = frame_last;

    pwm_dimmer u_pwm (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .brightness (brightness),
        .lit        (pwm_lit)
    );

    assign digit_on = active && pwm_lit && !(blink_phase && blink_snap[digit_idx]);

    // Slot / digit / frame counters, blink phase and snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_snap    <= {DIGITS{SEG_BLANK}};
            blink_snap  <= '0;
        end else begin
            if (slot_last) begin
                slot_cnt <= '0;
                if (digit_idx == DIG_W'(DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + DIG_W'(1);
                end
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            // Snapshot and blink toggle may both land on the same edge; both
            // become visible together at the start of the next frame.
            if (frame_last) begin
                seg_snap   <= segments_in;
                blink_snap <= blink_mask;
                if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    // Output register: one cycle behind the counters; a single anode at most.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an <= '1;
            ca <= SEG_BLANK;
        end else if (digit_on) begin
            an <= ~(DIGITS'(1) << digit_idx);
            ca <= seg_snap[digit_idx];
        end else begin
            an <= '1;
            ca <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with a small frame (16-cycle slots, 128-cycle frame).
// The reference model derives every pin value from the cycle number since reset:
// frame, digit and slot position come from division, blink phase from the frame
// number, and the per-frame data from a copy of the inputs taken at each frame end.
module tb_seven_segment_scanner;
    import sevens_pkg::*;

    localparam int DIGITS = 8;
    localparam int DIV    = 16;
    localparam int BLANK  = 2;
    localparam int BF     = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic                  clk;
    logic                  reset;
    seg_t [DIGITS-1:0]     segments_in;
    logic [DIGITS-1:0]     blink_mask;
    logic [3:0]            brightness;
    logic [DIGITS-1:0]     an;
    seg_t                  ca;
    logic                  frame_strobe;

    seven_segment_scanner #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .segments_in  (segments_in),
        .blink_mask   (blink_mask),
        .brightness   (brightness),
        .an           (an),
        .ca           (ca),
        .frame_strobe (frame_strobe)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fail_cnt  = 0;
    int   n         = 0;          // cycles since reset release (counter time)
    seg_t m_seg [DIGITS];         // data shown in the current frame
    logic [DIGITS-1:0] m_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < DIGITS; d++) m_seg[d] = SEG_BLANK;
        m_mask = '0;
    endtask

    // Advance one clock and compare the pins against the model for cycle n.
    task automatic one_cycle();
        int f, p, d, s, phase;
        bit lit;
        logic [DIGITS-1:0] exp_an;
        seg_t exp_ca;
        f = n / FRAME;
        p = n % FRAME;
        d = p / DIV;
        s = p % DIV;
        phase = (f / BF) % 2;
        lit = (s >= BLANK) && (((s - BLANK) % 16) <= int'(brightness))
              && !(phase == 1 && m_mask[d]);
        exp_an = lit ? ~(DIGITS'(1) << d) : '1;
        exp_ca = lit ? m_seg[d] : SEG_BLANK;
        if (p == FRAME - 1) begin
            for (int i = 0; i < DIGITS; i++) m_seg[i] = segments_in[i];
            m_mask = blink_mask;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("ca", 32'(ca), 32'(exp_ca));
        check("frame_strobe", 32'(frame_strobe), 32'(((n + 1) % FRAME) == FRAME - 1));
        check("an_single_low", 32'($countones(~an) <= 1), 32'd1);
        check("dark_ca", 32'((an == '1) ? ca : SEG_BLANK), 32'(SEG_BLANK));
        n++;
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) one_cycle();
    endtask

    initial begin
        int idx;
        reset       = 1'b1;
        segments_in = {DIGITS{SEG_BLANK}};
        blink_mask  = '0;
        brightness  = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(an), 32'hFF);
        check("reset_ca", 32'(ca), 32'hFF);
        check("reset_strobe", 32'(frame_strobe), 32'd0);

        // Load distinct patterns, full brightness, then release reset.
        for (int d = 0; d < DIGITS; d++) segments_in[d] = seg_t'(8'hC0 + d);
        reset = 1'b0;
        model_reset();

        // Frame 0 is dark (snapshot cleared), frame 1 shows C0+d.
        run_cycles(FRAME);
        // Mid-frame change of digit 5 must wait for the next capture.
        run_cycles(40);
        segments_in[5] = 8'h92;
        run_cycles(FRAME - 40);
        run_cycles(FRAME);

        // Dimming levels.
        brightness = 4'd3;
        run_cycles(FRAME);
        brightness = 4'd0;
        run_cycles(FRAME);

        // Blink digit 2.
        brightness = 4'd15;
        blink_mask = 8'h04;
        run_cycles(6 * FRAME);
        blink_mask = 8'h00;
        run_cycles(2 * FRAME);

        // Asynchronous reset while a digit is lit.
        while ((n % DIV) != 6) one_cycle();
        reset = 1'b1;
        #2;
        check("async_reset_an", 32'(an), 32'hFF);
        check("async_reset_ca", 32'(ca), 32'hFF);
        check("async_reset_strobe", 32'(frame_strobe), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run_cycles(FRAME);  // dark frame after reset

        // Randomized traffic: sparse random input changes on random cycles.
        for (int c = 0; c < 12 * FRAME; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, DIGITS - 1));
                segments_in[idx] = seg_t'($urandom);
            end
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) blink_mask = DIGITS'($urandom);
            one_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
